// File: rtl/micro86_pkg.sv
// Shared definitions for the micro86 memory-bus arbiter: FSM state codes,
// master indices and the round-robin tie-break helper.
package micro86_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_DONE   = 2'd2;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  typedef struct packed {
    logic        we;
    logic [15:0] address;
    logic [7:0]  wdata;
  } bus_req_t;

  // A lone requester always wins; on a tie the master that did not own the last access wins.
  function automatic logic pick_master(input logic req0, input logic req1, input logic last);
    logic sel;
    sel = MASTER_CPU;
    if (req0 && req1) sel = ~last;
    else if (req1)    sel = MASTER_DMA;
    return sel;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter.sv
// Two-master round-robin arbiter in front of memory_bus: registers the winning
// request, holds it on the bus for WAIT_CYCLES+1 cycles, then acks for one cycle.
module memory_bus_arbiter
  import micro86_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_address,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_address,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_in,
  input  logic [7:0]  bus_data_out,
  output logic        bus_enable,
  output logic        bus_write,
  output logic        busy,
  output logic        grant
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic       last_grant;
  logic [3:0] wait_cnt;
  logic       first_cycle;
  logic       access_we;
  logic       winner;
  bus_req_t   win_req;

  always_comb begin
    winner  = pick_master(m0_req, m1_req, last_grant);
    win_req = (winner == MASTER_DMA) ? '{m1_we, m1_address, m1_wdata}
                                     : '{m0_we, m0_address, m0_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_grant  <= MASTER_DMA;
      grant       <= MASTER_CPU;
      wait_cnt    <= '0;
      first_cycle <= 1'b0;
      access_we   <= 1'b0;
      bus_address <= '0;
      bus_data_in <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_req || m1_req) begin
            grant       <= winner;
            bus_address <= win_req.address;
            bus_data_in <= win_req.wdata;
            access_we   <= win_req.we;
            wait_cnt    <= WAIT_INIT;
            first_cycle <= 1'b1;
            state       <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          first_cycle <= 1'b0;
          if (wait_cnt == 4'd0) begin
            // Writes leave the granted master's rdata untouched.
            if (!access_we) begin
              if (grant == MASTER_DMA) m1_rdata <= bus_data_out;
              else                     m0_rdata <= bus_data_out;
            end
            state <= ARB_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ARB_DONE: begin
          last_grant <= grant;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Write strobe only in the first ACCESS cycle so peripherals never see a double write.
  always_comb begin
    busy       = (state != ARB_IDLE);
    bus_enable = (state == ARB_ACCESS);
    bus_write  = (state == ARB_ACCESS) && first_cycle && access_we;
    m0_ack     = (state == ARB_DONE) && (grant == MASTER_CPU);
    m1_ack     = (state == ARB_DONE) && (grant == MASTER_DMA);
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: directed scenarios plus two randomized
// masters, checked against a flat memory reference model.
module tb_memory_bus_arbiter;
  import micro86_pkg::*;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_address = '0;
  logic [7:0]  m0_wdata = '0;
  logic        m0_ack;
  logic [7:0]  m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_address = '0;
  logic [7:0]  m1_wdata = '0;
  logic        m1_ack;
  logic [7:0]  m1_rdata;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_in, bus_data_out;
  logic        bus_enable, bus_write, busy, grant;

  memory_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_enable(bus_enable), .bus_write(bus_write), .busy(busy), .grant(grant)
  );

  // Second instance with a slow peripheral timing, exercised by the write-strobe scenario.
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_wdata = '0;
  logic        p_ack, p1_ack, pbus_enable, pbus_write, p_busy, p_grant;
  logic [7:0]  p_rdata, p1_rdata, pbus_data_in;
  logic [7:0]  pbus_data_out;
  logic [15:0] pbus_address;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p1_addr = '0;
  logic [7:0]  p1_wdata = '0;
  assign pbus_data_out = 8'hC3;

  memory_bus_arbiter #(.WAIT_CYCLES(W3)) u_w3 (
    .clk(clk), .reset(reset),
    .m0_req(p_req), .m0_we(p_we), .m0_address(p_addr), .m0_wdata(p_wdata),
    .m0_ack(p_ack), .m0_rdata(p_rdata),
    .m1_req(p1_req), .m1_we(p1_we), .m1_address(p1_addr), .m1_wdata(p1_wdata),
    .m1_ack(p1_ack), .m1_rdata(p1_rdata),
    .bus_address(pbus_address), .bus_data_in(pbus_data_in), .bus_data_out(pbus_data_out),
    .bus_enable(pbus_enable), .bus_write(pbus_write), .busy(p_busy), .grant(p_grant)
  );

  // memory_bus stand-in and the reference memory, both seeded with the same pattern.
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign bus_data_out = mem[bus_address];

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a ^ (a >> 8) ^ 8'h5A);
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = init_byte(a);
      ref_mem[a] = init_byte(a);
    end
    forever begin
      @(posedge clk);
      if (!reset && bus_enable && bus_write) mem[bus_address] <= bus_data_in;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } item_t;

  item_t      q0[$];
  item_t      q1[$];
  int         ack_log[$];
  logic [7:0] exp_rd [2];
  int         en_cnt = 0, wr_cnt = 0;
  logic [15:0] cap_addr = '0;
  logic [7:0]  cap_wd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input int m);
    item_t it;
    logic [7:0] rd;
    rd = (m == 0) ? m0_rdata : m1_rdata;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      check($sformatf("m%0d_unexpected_ack", m), 64'd1, 64'd0);
    end else begin
      if (m == 0) it = q0.pop_front();
      else        it = q1.pop_front();
      check($sformatf("m%0d_rdata", m), rd, it.rdata);
      check($sformatf("m%0d_grant", m), grant, m);
      check($sformatf("m%0d_bus_address", m), cap_addr, it.addr);
      check($sformatf("m%0d_write_strobes", m), wr_cnt, it.we);
      check($sformatf("m%0d_enable_cycles", m), en_cnt, W + 1);
      if (it.we) check($sformatf("m%0d_bus_wdata", m), cap_wd, it.wdata);
    end
    ack_log.push_back(m);
    en_cnt = 0;
    wr_cnt = 0;
  endtask

  // Monitor: gathers bus activity per access and scores each ack against the queues.
  always @(negedge clk) begin
    if (reset) begin
      en_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (bus_enable) begin
        en_cnt++;
        if (en_cnt == 1) cap_addr = bus_address;
        if (bus_write) begin
          wr_cnt++;
          cap_wd = bus_data_in;
        end
      end
      if (m0_ack && m1_ack) check("both_acks", 64'd1, 64'd0);
      if (m0_ack) score(0);
      else if (m1_ack) score(1);
    end
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after a rising edge.
  task automatic issue(input int m, input logic we, input logic [15:0] a, input logic [7:0] d,
                       input int drop, output int lat);
    item_t it;
    int k;
    bit got;
    it.we = we;
    it.addr = a;
    it.wdata = d;
    if (we) begin
      ref_mem[a] = d;
      it.rdata = exp_rd[m];
    end else begin
      it.rdata = ref_mem[a];
      exp_rd[m] = it.rdata;
    end
    if (m == 0) begin
      q0.push_back(it);
      m0_req = 1'b1; m0_we = we; m0_address = a; m0_wdata = d;
    end else begin
      q1.push_back(it);
      m1_req = 1'b1; m1_we = we; m1_address = a; m1_wdata = d;
    end
    k = cyc + 1;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (drop >= 0 && i == drop) begin
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
      end
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        got = 1'b1;
        lat = cyc - k;
      end
    end
    if (!got) check($sformatf("m%0d_ack_timeout", m), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {m0_ack, m1_ack, m0_rdata, m1_rdata, bus_address, bus_data_in,
           bus_enable, bus_write, busy, grant}, 64'd0);
    reset = 1'b0;

    // Solo CPU read from ROM space; ack arrives W+1 cycles after the sampling edge.
    issue(0, 1'b0, 16'h4010, 8'h00, -1, lat);
    check("t1_latency", lat, W + 1);
    check("t1_rom_data", m0_rdata, init_byte(16'h4010));

    // DMA write then read-back of the same location.
    issue(1, 1'b1, 16'h0005, 8'hA5, -1, lat);
    check("t2_write_latency", lat, W + 1);
    issue(1, 1'b0, 16'h0005, 8'h00, -1, lat);
    check("t2_readback", m1_rdata, 8'hA5);

    // Simultaneous continuous requests after reset alternate starting with the CPU.
    do_reset();
    ack_log.delete();
    fork
      begin
        int l0;
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'h1000 + 16'(i), 8'h00, -1, l0);
      end
      begin
        int l1;
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 16'h2000 + 16'(i), 8'h00, -1, l1);
      end
    join
    check("t3_ack_count", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size() && i < 8; i++)
      check($sformatf("t3_order_%0d", i), ack_log[i], i % 2);

    // Reset in the middle of a DMA read aborts it; the CPU then wins the next tie.
    m1_req = 1'b1; m1_we = 1'b0; m1_address = 16'h2003;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_enable) seen = 1'b1;
    end
    check("t5_access_started", seen, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_outputs_cleared",
          {m0_ack, m1_ack, m0_rdata, m1_rdata, bus_address, bus_data_in,
           bus_enable, bus_write, busy, grant}, 64'd0);
    m1_req = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b0;
    ack_log.delete();
    fork
      begin
        int l2;
        issue(0, 1'b0, 16'h1008, 8'h00, -1, l2);
      end
      begin
        int l3;
        issue(1, 1'b0, 16'h2008, 8'h00, -1, l3);
      end
    join
    check("t5_tie_winner", (ack_log.size() > 0) ? ack_log[0] : -1, 0);

    // CPU drops its request mid-access: the access still completes with one ack.
    issue(0, 1'b0, 16'h1005, 8'h00, 1, lat);
    check("t6_latency", lat, W + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_idle_%0d", i), {busy, bus_enable}, 2'b00);
    end
    @(posedge clk);
    #1;

    // Randomized traffic from both masters over small disjoint address windows.
    fork
      begin
        int l4;
        for (int i = 0; i < 30; i++) begin
          step($urandom_range(0, 3));
          issue(0, 1'($urandom_range(0, 1)), 16'h1000 | 16'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), -1, l4);
        end
      end
      begin
        int l5;
        for (int i = 0; i < 30; i++) begin
          step($urandom_range(0, 3));
          issue(1, 1'($urandom_range(0, 1)), 16'h2000 | 16'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), -1, l5);
        end
      end
    join
    step(4);
    check("rand_queues_drained", q0.size() + q1.size(), 0);

    // Peripheral write with three wait cycles on the second instance.
    begin
      int k, en, wr, plat;
      p_req = 1'b1; p_we = 1'b1; p_addr = 16'h8000; p_wdata = 8'h3C;
      k = cyc + 1;
      en = 0;
      wr = 0;
      plat = -1;
      for (int i = 0; i < 40 && plat < 0; i++) begin
        @(negedge clk);
        if (pbus_enable) en++;
        if (pbus_write) begin
          wr++;
          check("t4_strobe_addr_data", {pbus_address, pbus_data_in}, {16'h8000, 8'h3C});
        end
        if (p_ack) plat = cyc - k;
      end
      check("t4_latency", plat, W3 + 1);
      check("t4_enable_cycles", en, W3 + 1);
      check("t4_write_strobes", wr, 1);
      check("t4_rdata_kept", p_rdata, 8'h00);
      @(posedge clk);
      #1;
      p_req = 1'b0;
    end

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
